// File: rtl/seq_mult_dot_ctrl.sv
// Dot-product controller for the 6-bit shift-add multiplier: feeds operand
// pairs, waits out the multiplier iterations, accumulates products and emits the sum.
module seq_mult_dot_ctrl #(
  parameter int W          = 6,
  parameter int LEN        = 4,
  parameter int MUL_CYCLES = 6,
  parameter int ACC_W      = 14,
  parameter int TC_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             mul_load,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [TC_W-1:0]  out_terms
);

  localparam int WC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_next;
  logic [TC_W-1:0]  term_cnt;
  logic [WC_W-1:0]  wait_cnt;
  logic             last_flag;

  always_comb begin
    sum_next = acc + {{(ACC_W-2*W){1'b0}}, mul_product};
  end

  assign in_ready = (state == S_IDLE);
  assign mul_load = (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      term_cnt  <= '0;
      wait_cnt  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_terms <= '0;
      last_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            last_flag <= in_last;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // product settles on the edge that leaves the final WAIT cycle
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WC_W'(MUL_CYCLES - 1)) state <= S_ACC;
        end
        S_ACC: begin
          acc      <= sum_next;
          term_cnt <= term_cnt + 1'b1;
          if (last_flag || term_cnt == TC_W'(LEN - 1)) begin
            out_sum   <= sum_next;
            out_terms <= term_cnt + 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            term_cnt  <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_dot_ctrl.sv
// Directed bench for seq_mult_dot_ctrl with a behavioural shift-add multiplier
// whose product is only correct MUL_CYCLES edges after the load strobe.
module tb_seq_mult_dot_ctrl;
  localparam int W = 6, LEN = 4, MUL_CYCLES = 6, ACC_W = 14, TC_W = 3;

  logic             clk, rst;
  logic             in_valid, in_ready, in_last;
  logic [W-1:0]     in_a, in_b;
  logic             mul_load;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   mul_product;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [TC_W-1:0]  out_terms;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [W-1:0] ta [4];
  logic [W-1:0] tbv [4];
  logic         tl [4];
  int cyc, loads, changes, rdy_hi, accepts;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_mult_dot_ctrl #(.W(W), .LEN(LEN), .MUL_CYCLES(MUL_CYCLES), .ACC_W(ACC_W), .TC_W(TC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_terms(out_terms)
  );

  // Multiplier model: garbage while iterating, exact product after MUL_CYCLES edges.
  logic [W-1:0] ra, rb;
  int           mcnt;
  always @(posedge clk) begin
    if (rst) begin
      mul_product <= '0; mcnt <= MUL_CYCLES; ra <= '0; rb <= '0;
    end else if (mul_load) begin
      ra <= mul_a; rb <= mul_b; mcnt <= 0; mul_product <= 12'hABC;
    end else if (mcnt < MUL_CYCLES) begin
      mcnt <= mcnt + 1;
      if (mcnt == MUL_CYCLES - 1) mul_product <= ra * rb;
      else mul_product <= mul_product ^ 12'h5A5;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Streams n pairs with in_valid held high until the last is accepted, then
  // waits (bounded) for out_valid while observing the multiplier interface.
  task automatic run_dot(input int n, output int cycles, output int nload,
                         output int nchg, output int nrdy, output int nacc);
    int idx;
    logic [W-1:0] ca, cb;
    bit cap, acc_now;
    idx = 0; cap = 0; cycles = 0; nload = 0; nchg = 0; nrdy = 0; nacc = 0;
    ca = '0; cb = '0;
    in_a = ta[0]; in_b = tbv[0]; in_last = tl[0]; in_valid = 1'b1;
    while (cycles < 200 && out_valid !== 1'b1) begin
      cycles++;
      if (in_ready) nrdy++;
      if (mul_load) begin nload++; ca = mul_a; cb = mul_b; cap = 1; end
      else if (cap && (mul_a !== ca || mul_b !== cb)) nchg++;
      acc_now = in_ready && in_valid;
      tick();
      if (acc_now) begin
        nacc++; idx++;
        if (idx < n) begin in_a = ta[idx]; in_b = tbv[idx]; in_last = tl[idx]; end
        else in_valid = 1'b0;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_last = 0; out_ready = 0;
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0d want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_sum !== 14'd0) $display("FAIL reset_out_sum: got %0d want 0", out_sum); else pass_cnt++;
    total_cnt++; if (out_terms !== 3'd0) $display("FAIL reset_out_terms: got %0d want 0", out_terms); else pass_cnt++;
    total_cnt++; if (mul_load !== 1'b0) $display("FAIL reset_mul_load: got %0d want 0", mul_load); else pass_cnt++;
    total_cnt++; if (mul_a !== 6'd0 || mul_b !== 6'd0) $display("FAIL reset_mul_ab: got %0d,%0d want 0,0", mul_a, mul_b); else pass_cnt++;
    rst = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL idle_out_ready: got valid=%0d ready=%0d want 0,1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    ta[0] = 6'd5; tbv[0] = 6'd7; tl[0] = 1'b1;
    run_dot(1, cyc, loads, changes, rdy_hi, accepts);
    total_cnt++; if (cyc !== 9) $display("FAIL single_latency: got %0d want 9", cyc); else pass_cnt++;
    total_cnt++; if (loads !== 1) $display("FAIL single_load_pulse: got %0d want 1", loads); else pass_cnt++;
    total_cnt++; if (changes !== 0) $display("FAIL single_ab_stable: got %0d want 0", changes); else pass_cnt++;
    total_cnt++; if (rdy_hi !== 1) $display("FAIL single_in_ready_busy: got %0d want 1", rdy_hi); else pass_cnt++;
    total_cnt++; if (out_sum !== 14'd35) $display("FAIL single_sum: got %0d want 35", out_sum); else pass_cnt++;
    total_cnt++; if (out_terms !== 3'd1) $display("FAIL single_terms: got %0d want 1", out_terms); else pass_cnt++;
    consume();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL single_consume: got valid=%0d ready=%0d want 0,1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 4; i++) begin ta[i] = 6'd63; tbv[i] = 6'd63; tl[i] = 1'b0; end
    run_dot(4, cyc, loads, changes, rdy_hi, accepts);
    total_cnt++; if (cyc !== 36) $display("FAIL maxlen_cycles: got %0d want 36", cyc); else pass_cnt++;
    total_cnt++; if (rdy_hi !== 4 || accepts !== 4) $display("FAIL maxlen_ready: got %0d/%0d want 4/4", rdy_hi, accepts); else pass_cnt++;
    total_cnt++; if (loads !== 4 || changes !== 0) $display("FAIL maxlen_mul_if: got loads=%0d chg=%0d want 4,0", loads, changes); else pass_cnt++;
    total_cnt++; if (out_sum !== 14'd15876) $display("FAIL maxlen_sum: got %0d want 15876", out_sum); else pass_cnt++;
    total_cnt++; if (out_terms !== 3'd4) $display("FAIL maxlen_terms: got %0d want 4", out_terms); else pass_cnt++;
    consume();
  endtask

  task automatic test_early_last();
    ta[0] = 6'd3; tbv[0] = 6'd4; tl[0] = 1'b0;
    ta[1] = 6'd0; tbv[1] = 6'd63; tl[1] = 1'b0;
    ta[2] = 6'd10; tbv[2] = 6'd10; tl[2] = 1'b1;
    run_dot(3, cyc, loads, changes, rdy_hi, accepts);
    total_cnt++; if (cyc !== 27) $display("FAIL early_cycles: got %0d want 27", cyc); else pass_cnt++;
    total_cnt++; if (out_sum !== 14'd112) $display("FAIL early_sum: got %0d want 112", out_sum); else pass_cnt++;
    total_cnt++; if (out_terms !== 3'd3) $display("FAIL early_terms: got %0d want 3", out_terms); else pass_cnt++;
    consume();
    ta[0] = 6'd1; tbv[0] = 6'd1; tl[0] = 1'b1;
    run_dot(1, cyc, loads, changes, rdy_hi, accepts);
    total_cnt++; if (out_sum !== 14'd1 || out_terms !== 3'd1) $display("FAIL early_next_from_zero: got sum=%0d terms=%0d want 1,1", out_sum, out_terms); else pass_cnt++;
    consume();
  endtask

  task automatic test_backpressure();
    int bad_hold, bad_rdy, bad_ab, extra;
    bad_hold = 0; bad_rdy = 0; bad_ab = 0; extra = 0;
    ta[0] = 6'd1; tbv[0] = 6'd2; tl[0] = 1'b0;
    ta[1] = 6'd3; tbv[1] = 6'd4; tl[1] = 1'b0;
    ta[2] = 6'd5; tbv[2] = 6'd6; tl[2] = 1'b0;
    ta[3] = 6'd7; tbv[3] = 6'd8; tl[3] = 1'b1;
    run_dot(4, cyc, loads, changes, rdy_hi, accepts);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid_timeout: got %0d want 1", out_valid); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_sum !== 14'd100 || out_terms !== 3'd4) bad_hold++;
      if (in_ready !== 1'b0) bad_rdy++;
      if (mul_a !== 6'd7 || mul_b !== 6'd8) bad_ab++;
      in_valid = (i % 2 == 0); in_a = 6'(i + 9); in_b = 6'(i + 3); in_last = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    total_cnt++; if (bad_hold !== 0) $display("FAIL bp_sum_held: got %0d unstable cycles want 0", bad_hold); else pass_cnt++;
    total_cnt++; if (bad_rdy !== 0) $display("FAIL bp_in_ready_low: got %0d high cycles want 0", bad_rdy); else pass_cnt++;
    total_cnt++; if (bad_ab !== 0) $display("FAIL bp_mul_ab_held: got %0d changes want 0", bad_ab); else pass_cnt++;
    consume();
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release: got ready=%0d valid=%0d want 1,0", in_ready, out_valid); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b0) extra++;
      tick();
    end
    total_cnt++; if (extra !== 0) $display("FAIL bp_single_emit: got %0d extra valid cycles want 0", extra); else pass_cnt++;
    ta[0] = 6'd2; tbv[0] = 6'd2; tl[0] = 1'b1;
    run_dot(1, cyc, loads, changes, rdy_hi, accepts);
    total_cnt++; if (out_sum !== 14'd4 || out_terms !== 3'd1) $display("FAIL bp_pulses_ignored: got sum=%0d terms=%0d want 4,1", out_sum, out_terms); else pass_cnt++;
    consume();
  endtask

  task automatic test_reset_mid();
    int k;
    in_a = 6'd4; in_b = 6'd5; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (in_ready !== 1'b1 && k < 30) begin tick(); k++; end
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_first_term_timeout: got %0d want 1", in_ready); else pass_cnt++;
    in_a = 6'd6; in_b = 6'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || out_sum !== 14'd0 || out_terms !== 3'd0) $display("FAIL rstmid_outputs: got valid=%0d sum=%0d terms=%0d want 0,0,0", out_valid, out_sum, out_terms); else pass_cnt++;
    total_cnt++; if (mul_load !== 1'b0 || mul_a !== 6'd0 || mul_b !== 6'd0) $display("FAIL rstmid_mul_if: got load=%0d a=%0d b=%0d want 0,0,0", mul_load, mul_a, mul_b); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_idle: got %0d want 1", in_ready); else pass_cnt++;
    rst = 1'b0;
    ta[0] = 6'd2; tbv[0] = 6'd3; tl[0] = 1'b1;
    run_dot(1, cyc, loads, changes, rdy_hi, accepts);
    total_cnt++; if (out_sum !== 14'd6 || out_terms !== 3'd1) $display("FAIL rstmid_restart: got sum=%0d terms=%0d want 6,1", out_sum, out_terms); else pass_cnt++;
    total_cnt++; if (cyc !== 9) $display("FAIL rstmid_latency: got %0d want 9", cyc); else pass_cnt++;
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_max_len();
    test_early_last();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
